mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 14 +
 rtl/mem_bus_arbiter_arb_select.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
// Arbitration mode is selected by MEM_ARB_FIXED_PRIO_EN (see arb_select).
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_arb_select.sv
// Combinational winner selection between the core (m0) and loader (m1) requesters.
// MEM_ARB_FIXED_PRIO_EN defined: m0 wins ties; otherwise round-robin on last_grant.
module arb_select
    import mem_bus_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner
);

    always_comb begin
        winner = OWNER_M0;
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            winner = OWNER_M0;
`else
            winner = (last_grant == OWNER_M0) ? OWNER_M1 : OWNER_M0;
`endif
        end else if (req1) begin
            winner = OWNER_M1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: IDLE -> ISSUE (strobe) -> RESP (ack), one transaction per 3 cycles.
// MEM_ARB_FIXED_PRIO_EN defined removes the last-grant register and gives m0 fixed priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic                  m0_ack_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic                  m1_ack_o,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  rd_en_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  busy_o
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    cap_we;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_data;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    owner;
    logic                    last_grant;
    logic                    winner;
    logic                    any_req;
    logic                    capture;

    assign any_req = m0_req_i | m1_req_i;
    assign capture = (state == IDLE) && any_req;

    arb_select u_arb_select (
        .req0       (m0_req_i),
        .req1       (m1_req_i),
        .last_grant (last_grant),
        .winner     (winner)
    );

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign last_grant = OWNER_M1;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= OWNER_M1;
        end else if (capture) begin
            last_grant <= winner;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap_we   <= 1'b0;
            cap_addr <= '0;
            cap_data <= '0;
            owner    <= OWNER_M0;
            rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                owner <= winner;
                if (winner == OWNER_M1) begin
                    cap_we   <= m1_we_i;
                    cap_addr <= m1_addr_i;
                    cap_data <= m1_data_i;
                end else begin
                    cap_we   <= m0_we_i;
                    cap_addr <= m0_addr_i;
                    cap_data <= m0_data_i;
                end
            end
            // memory read data is taken at the ISSUE->RESP edge and held for the ack cycle
            if (state == ISSUE && !cap_we) begin
                rdata <= data_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en_o   = 1'b0;
        wr_en_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_data_o = '0;
        m1_data_o = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
                rd_en_o   = ~cap_we;
                wr_en_o   = cap_we;
            end
            RESP: begin
                state_nxt = IDLE;
                if (owner == OWNER_M0) begin
                    m0_ack_o  = 1'b1;
                    m0_data_o = cap_we ? '0 : rdata;
                end else begin
                    m1_ack_o  = 1'b1;
                    m1_data_o = cap_we ? '0 : rdata;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign addr_o = cap_addr;
    assign data_o = cap_data;
    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model; honours MEM_ARB_FIXED_PRIO_EN.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mreq [2];
    logic        mwe  [2];
    logic [31:0] maddr[2];
    logic [31:0] mdata[2];
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] m0_data_o, m1_data_o;
    logic        rd_en_o, wr_en_o, busy_o;
    logic [31:0] addr_o, data_o, data_i;

    logic [31:0] mem    [0:1023];
    logic [31:0] ref_mem[0:1023];

    int checks   = 0;
    int failures = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req_i  (mreq[0]),
        .m0_we_i   (mwe[0]),
        .m0_addr_i (maddr[0]),
        .m0_data_i (mdata[0]),
        .m0_ack_o  (m0_ack_o),
        .m0_data_o (m0_data_o),
        .m1_req_i  (mreq[1]),
        .m1_we_i   (mwe[1]),
        .m1_addr_i (maddr[1]),
        .m1_data_i (mdata[1]),
        .m1_ack_o  (m1_ack_o),
        .m1_data_o (m1_data_o),
        .rd_en_o   (rd_en_o),
        .wr_en_o   (wr_en_o),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .data_i    (data_i),
        .busy_o    (busy_o)
    );

    assign data_i = mem[addr_o[11:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // memory write lands at the edge closing the cycle in which wr_en_o is seen
    task automatic step();
        if (wr_en_o === 1'b1) mem[addr_o[11:2]] = data_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b0; mwe[m] = 1'b0; maddr[m] = '0; mdata[m] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        idle_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b1; mwe[m] = 1'($urandom); maddr[m] = $urandom; mdata[m] = $urandom;
        end
        step();
        step();
        checks++;
        if ({rd_en_o, wr_en_o, busy_o, m0_ack_o, m1_ack_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {rd_en_o, wr_en_o, busy_o, m0_ack_o, m1_ack_o});
        end
        checks++;
        if ({addr_o, data_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%h data=%h expected 0", addr_o, data_o);
        end
        checks++;
        if ({m0_data_o, m1_data_o} !== 64'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h %h expected 0", m0_data_o, m1_data_o);
        end
        idle_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read();
        mem[64] = 32'hDEADBEEF;
        mreq[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 32'h100; mdata[0] = 32'h5555_AAAA;
        step();
        checks++;
        if ({rd_en_o, wr_en_o, addr_o} !== {2'b10, 32'h100}) begin
            failures++;
            $display("FAIL read_strobe: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=00000100", rd_en_o, wr_en_o, addr_o);
        end
        step();
        checks++;
        if ({m0_ack_o, m0_data_o, m1_ack_o, rd_en_o} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL read_ack: got ack0=%b d0=%h ack1=%b rd=%b expected 1 deadbeef 0 0", m0_ack_o, m0_data_o, m1_ack_o, rd_en_o);
        end
        step();
        mreq[0] = 1'b0;
        checks++;
        if ({m0_ack_o, busy_o} !== 2'b00) begin
            failures++;
            $display("FAIL read_ack_width: got ack0=%b busy=%b expected 0 0", m0_ack_o, busy_o);
        end
        step();
    endtask

    task automatic test_write();
        mreq[1] = 1'b1; mwe[1] = 1'b1; maddr[1] = 32'h200; mdata[1] = 32'h12345678;
        step();
        checks++;
        if ({wr_en_o, rd_en_o, addr_o, data_o, m1_ack_o} !== {2'b10, 32'h200, 32'h12345678, 1'b0}) begin
            failures++;
            $display("FAIL write_strobe: got wr=%b rd=%b addr=%h data=%h ack1=%b expected 1 0 00000200 12345678 0", wr_en_o, rd_en_o, addr_o, data_o, m1_ack_o);
        end
        step();
        checks++;
        if ({m1_ack_o, m1_data_o, m0_ack_o, wr_en_o} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL write_ack: got ack1=%b d1=%h ack0=%b wr=%b expected 1 0 0 0", m1_ack_o, m1_data_o, m0_ack_o, wr_en_o);
        end
        step();
        mreq[1] = 1'b0;
        checks++;
        if (mem[128] !== 32'h12345678) begin
            failures++;
            $display("FAIL write_mem: got %h expected 12345678", mem[128]);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic exp_own;
        do_reset();
        mreq[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 32'h10; mdata[0] = 32'h0;
        mreq[1] = 1'b1; mwe[1] = 1'b0; maddr[1] = 32'h20; mdata[1] = 32'h0;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_own = 1'b0;
`else
            exp_own = k[0];
`endif
            step();
            checks++;
            if (addr_o !== (exp_own ? 32'h20 : 32'h10)) begin
                failures++;
                $display("FAIL rr_grant%0d: got addr=%h expected %h", k, addr_o, exp_own ? 32'h20 : 32'h10);
            end
            step();
            checks++;
            if ({m0_ack_o, m1_ack_o} !== {~exp_own, exp_own}) begin
                failures++;
                $display("FAIL rr_ack%0d: got ack0=%b ack1=%b expected %b %b", k, m0_ack_o, m1_ack_o, ~exp_own, exp_own);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_addr_hold();
        mreq[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 32'h100; mdata[0] = 32'h0;
        step();
        maddr[0] = 32'h300; mwe[0] = 1'b1; mdata[0] = $urandom;
        checks++;
        if ({rd_en_o, addr_o} !== {1'b1, 32'h100}) begin
            failures++;
            $display("FAIL hold_issue: got rd=%b addr=%h expected 1 00000100", rd_en_o, addr_o);
        end
        step();
        checks++;
        if ({addr_o, m0_ack_o, m0_data_o} !== {32'h100, 1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL hold_resp: got addr=%h ack0=%b d0=%h expected 00000100 1 deadbeef", addr_o, m0_ack_o, m0_data_o);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        mreq[1] = 1'b1; mwe[1] = 1'b0; maddr[1] = 32'h200; mdata[1] = 32'h0;
        step();
        checks++;
        if (rd_en_o !== 1'b1) begin
            failures++;
            $display("FAIL midrst_issue: got rd=%b expected 1", rd_en_o);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({rd_en_o, wr_en_o, busy_o, m0_ack_o, m1_ack_o, addr_o, data_o, m1_data_o} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: got rd=%b wr=%b busy=%b ack0=%b ack1=%b addr=%h data=%h d1=%h expected all 0", rd_en_o, wr_en_o, busy_o, m0_ack_o, m1_ack_o, addr_o, data_o, m1_data_o);
        end
        rst_n = 1'b1;
        idle_inputs();
        step();
        checks++;
        if ({rd_en_o, wr_en_o, m1_ack_o, busy_o} !== 4'b0) begin
            failures++;
            $display("FAIL midrst_after: got rd=%b wr=%b ack1=%b busy=%b expected 0 0 0 0", rd_en_o, wr_en_o, m1_ack_o, busy_o);
        end
        mreq[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 32'h100;
        step();
        step();
        checks++;
        if ({m0_ack_o, m0_data_o, m1_ack_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL midrst_fresh: got ack0=%b d0=%h ack1=%b expected 1 deadbeef 0", m0_ack_o, m0_data_o, m1_ack_o);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        int busy_low = 0;
        mreq[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 32'h100;
        for (int t = 1; t <= 9; t++) begin
            step();
            if (!busy_o) busy_low++;
            checks++;
            if ({busy_o, rd_en_o, m0_ack_o} !== {(t % 3) != 0, (t % 3) == 1, (t % 3) == 2}) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got busy=%b rd=%b ack0=%b expected %b %b %b", t, busy_o, rd_en_o, m0_ack_o, (t % 3) != 0, (t % 3) == 1, (t % 3) == 2);
            end
        end
        mreq[0] = 1'b0;
        checks++;
        if (busy_low != 3) begin
            failures++;
            $display("FAIL b2b_idle_count: got %0d expected 3", busy_low);
        end
        step();
    endtask

    task automatic test_random();
        int          phase;
        logic        own, twe, last;
        logic [31:0] taddr, tdata;
        logic        preq[2], pwe[2], done[2];
        logic [31:0] paddr[2], pdata[2];
        logic        e_rd, e_wr, e_busy, e_ack0, e_ack1;
        logic [31:0] e_d0, e_d1;

        do_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        phase = 0; own = 1'b0; twe = 1'b0; last = 1'b1; taddr = '0; tdata = '0;
        for (int m = 0; m < 2; m++) done[m] = 1'b0;

        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (done[m] || (!mreq[m] && $urandom_range(0, 2) == 0)) begin
                    if (done[m] && $urandom_range(0, 3) != 0) begin
                        mreq[m] = 1'b0;
                        mwe[m] = 1'($urandom); maddr[m] = $urandom; mdata[m] = $urandom;
                    end else begin
                        mreq[m] = 1'b1; mwe[m] = 1'($urandom);
                        maddr[m] = 32'h100 + 32'($urandom_range(0, 15) * 4);
                        mdata[m] = $urandom;
                    end
                    done[m] = 1'b0;
                end
                preq[m] = mreq[m]; pwe[m] = mwe[m]; paddr[m] = maddr[m]; pdata[m] = mdata[m];
            end
            step();

            if (phase == 0) begin
                if (preq[0] || preq[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    own = (preq[0] && preq[1]) ? 1'b0 : preq[1];
`else
                    own = (preq[0] && preq[1]) ? ~last : preq[1];
`endif
                    last = own;
                    twe = pwe[own]; taddr = paddr[own]; tdata = pdata[own];
                    phase = 1;
                end
            end else if (phase == 1) begin
                phase = 2;
                if (twe) ref_mem[taddr[11:2]] = tdata;
            end else begin
                phase = 0;
            end

            e_rd   = (phase == 1) && !twe;
            e_wr   = (phase == 1) && twe;
            e_busy = (phase != 0);
            e_ack0 = (phase == 2) && !own;
            e_ack1 = (phase == 2) && own;
            e_d0   = (e_ack0 && !twe) ? ref_mem[taddr[11:2]] : 32'h0;
            e_d1   = (e_ack1 && !twe) ? ref_mem[taddr[11:2]] : 32'h0;

            checks++;
            if ({rd_en_o, wr_en_o, busy_o, m0_ack_o, m1_ack_o} !== {e_rd, e_wr, e_busy, e_ack0, e_ack1}) begin
                failures++;
                $display("FAIL rand_ctrl c%0d: got rd/wr/busy/ack0/ack1=%b expected %b", c, {rd_en_o, wr_en_o, busy_o, m0_ack_o, m1_ack_o}, {e_rd, e_wr, e_busy, e_ack0, e_ack1});
            end
            checks++;
            if ({addr_o, data_o} !== {taddr, tdata}) begin
                failures++;
                $display("FAIL rand_bus c%0d: got addr=%h data=%h expected %h %h", c, addr_o, data_o, taddr, tdata);
            end
            checks++;
            if ({m0_data_o, m1_data_o} !== {e_d0, e_d1}) begin
                failures++;
                $display("FAIL rand_rdata c%0d: got d0=%h d1=%h expected %h %h", c, m0_data_o, m1_data_o, e_d0, e_d1);
            end
            if (phase == 2) done[own] = 1'b1;
        end
        idle_inputs();
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_addr_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
